// File: rtl/cnn_accel_cfg_slave.sv
// AHB-Lite configuration slave for the CNN accelerator.
// Holds frame/delay/base-address/layer configuration, launches a layer with a
// one-cycle start pulse and tracks layer completion in a small control FSM.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no layer running, configuration writable
// ST_BUSY   | layer running, configuration locked, waiting for i_layer_done
// ST_DONE   | layer finished, done/irq set until cleared or restarted
module cnn_accel_cfg_slave #(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int W_SIZE  = 12,
    parameter int W_DELAY = 12,
    parameter int W_BURST = 3
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 sl_HSEL,
    input  logic                 sl_HREADY,
    input  logic [1:0]           sl_HTRANS,
    input  logic [W_BURST-1:0]   sl_HBURST,
    input  logic [2:0]           sl_HSIZE,
    input  logic [W_ADDR-1:0]    sl_HADDR,
    input  logic                 sl_HWRITE,
    input  logic [W_DATA-1:0]    sl_HWDATA,
    output logic                 out_sl_HREADY,
    output logic [1:0]           out_sl_HRESP,
    output logic [W_DATA-1:0]    out_sl_HRDATA,
    input  logic                 i_layer_done,
    output logic [2*W_SIZE:0]    o_frame_size,
    output logic [W_SIZE-1:0]    o_width,
    output logic [W_SIZE-1:0]    o_height,
    output logic [W_DELAY-1:0]   o_start_up_delay,
    output logic [W_DELAY-1:0]   o_hsync_delay,
    output logic [19:0]          o_base_addr_weight,
    output logic [11:0]          o_base_addr_param,
    output logic [15:0]          o_layer_cfg,
    output logic                 o_layer_start,
    output logic                 o_busy,
    output logic                 o_irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] OFF_FRAME  = 6'h00;
    localparam logic [5:0] OFF_WH     = 6'h01;
    localparam logic [5:0] OFF_DELAY  = 6'h02;
    localparam logic [5:0] OFF_BASE   = 6'h03;
    localparam logic [5:0] OFF_LAYER  = 6'h04;
    localparam logic [5:0] OFF_START  = 6'h05;
    localparam logic [5:0] OFF_STATUS = 6'h06;

    // Address-phase capture
    logic                dp_valid_q, dp_valid_d;
    logic                dp_write_q, dp_write_d;
    logic [5:0]          dp_addr_q, dp_addr_d;

    // Configuration registers
    logic [2*W_SIZE:0]   frame_size_q, frame_size_d;
    logic [W_SIZE-1:0]   width_q, width_d;
    logic [W_SIZE-1:0]   height_q, height_d;
    logic [W_DELAY-1:0]  start_up_q, start_up_d;
    logic [W_DELAY-1:0]  hsync_q, hsync_d;
    logic [19:0]         weight_q, weight_d;
    logic [11:0]         param_q, param_d;
    logic [15:0]         layer_cfg_q, layer_cfg_d;

    // Control
    logic [1:0]          state_q, state_d;
    logic                done_q, done_d;
    logic                start_err_q, start_err_d;
    logic                layer_start_q, layer_start_d;
    logic [W_DATA-1:0]   rdata_q, rdata_d;

    logic                xfer_valid;
    logic                wr_commit;
    logic                cfg_wr;
    logic                start_req;
    logic                done_clr;
    logic                err_clr;
    logic [W_DATA-1:0]   rd_word;
    logic                unused_bits;

    assign unused_bits = ^{sl_HBURST, sl_HADDR[W_ADDR-1:8], sl_HADDR[1:0], sl_HTRANS[0]};

    // Transfer qualification and data-phase write decode
    always_comb begin
        xfer_valid = sl_HSEL & sl_HREADY & sl_HTRANS[1] & (sl_HSIZE == 3'b010);
        dp_valid_d = xfer_valid;
        dp_write_d = sl_HWRITE;
        dp_addr_d  = sl_HADDR[7:2];
        wr_commit  = dp_valid_q & dp_write_q;
        cfg_wr     = wr_commit & (state_q != ST_BUSY);
        start_req  = wr_commit & (dp_addr_q == OFF_START) & sl_HWDATA[0];
        done_clr   = wr_commit & (dp_addr_q == OFF_STATUS) & sl_HWDATA[1];
        err_clr    = wr_commit & (dp_addr_q == OFF_STATUS) & sl_HWDATA[2];
    end

    // Configuration register updates; locked while a layer runs
    always_comb begin
        frame_size_d = frame_size_q;
        width_d      = width_q;
        height_d     = height_q;
        start_up_d   = start_up_q;
        hsync_d      = hsync_q;
        weight_d     = weight_q;
        param_d      = param_q;
        layer_cfg_d  = layer_cfg_q;
        if (cfg_wr) begin
            case (dp_addr_q)
                OFF_FRAME: frame_size_d = sl_HWDATA[2*W_SIZE:0];
                OFF_WH: begin
                    width_d  = sl_HWDATA[W_SIZE-1:0];
                    height_d = sl_HWDATA[16 +: W_SIZE];
                end
                OFF_DELAY: begin
                    start_up_d = sl_HWDATA[W_DELAY-1:0];
                    hsync_d    = sl_HWDATA[12 +: W_DELAY];
                end
                OFF_BASE: begin
                    weight_d = sl_HWDATA[19:0];
                    param_d  = sl_HWDATA[31:20];
                end
                OFF_LAYER: layer_cfg_d = sl_HWDATA[15:0];
                default: ;
            endcase
        end
    end

    // Layer control FSM; a done set from the datapath beats a same-cycle clear
    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        start_err_d   = start_err_q;
        layer_start_d = 1'b0;
        if (err_clr) begin
            start_err_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d       = ST_BUSY;
                    layer_start_d = 1'b1;
                    done_d        = 1'b0;
                end
            end
            ST_BUSY: begin
                if (start_req) begin
                    start_err_d = 1'b1;
                end
                if (done_clr) begin
                    done_d = 1'b0;
                end
                if (i_layer_done) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                if (start_req) begin
                    state_d       = ST_BUSY;
                    layer_start_d = 1'b1;
                    done_d        = 1'b0;
                end else if (done_clr) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    // Read mux built from next-state values so a same-edge write is forwarded
    always_comb begin
        rd_word = '0;
        case (sl_HADDR[7:2])
            OFF_FRAME: rd_word[2*W_SIZE:0] = frame_size_d;
            OFF_WH: begin
                rd_word[W_SIZE-1:0]   = width_d;
                rd_word[16 +: W_SIZE] = height_d;
            end
            OFF_DELAY: begin
                rd_word[W_DELAY-1:0]   = start_up_d;
                rd_word[12 +: W_DELAY] = hsync_d;
            end
            OFF_BASE: begin
                rd_word[19:0]  = weight_d;
                rd_word[31:20] = param_d;
            end
            OFF_LAYER: rd_word[15:0] = layer_cfg_d;
            OFF_STATUS: begin
                rd_word[0] = (state_d == ST_BUSY);
                rd_word[1] = done_d;
                rd_word[2] = start_err_d;
            end
            default: ;
        endcase
        rdata_d = rdata_q;
        if (xfer_valid & ~sl_HWRITE) begin
            rdata_d = rd_word;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_valid_q    <= 1'b0;
            dp_write_q    <= 1'b0;
            dp_addr_q     <= '0;
            frame_size_q  <= '0;
            width_q       <= '0;
            height_q      <= '0;
            start_up_q    <= '0;
            hsync_q       <= '0;
            weight_q      <= '0;
            param_q       <= '0;
            layer_cfg_q   <= '0;
            state_q       <= ST_IDLE;
            done_q        <= 1'b0;
            start_err_q   <= 1'b0;
            layer_start_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            dp_valid_q    <= dp_valid_d;
            dp_write_q    <= dp_write_d;
            dp_addr_q     <= dp_addr_d;
            frame_size_q  <= frame_size_d;
            width_q       <= width_d;
            height_q      <= height_d;
            start_up_q    <= start_up_d;
            hsync_q       <= hsync_d;
            weight_q      <= weight_d;
            param_q       <= param_d;
            layer_cfg_q   <= layer_cfg_d;
            state_q       <= state_d;
            done_q        <= done_d;
            start_err_q   <= start_err_d;
            layer_start_q <= layer_start_d;
            rdata_q       <= rdata_d;
        end
    end

    assign out_sl_HREADY      = 1'b1;
    assign out_sl_HRESP       = 2'b00;
    assign out_sl_HRDATA      = rdata_q;
    assign o_frame_size       = frame_size_q;
    assign o_width            = width_q;
    assign o_height           = height_q;
    assign o_start_up_delay   = start_up_q;
    assign o_hsync_delay      = hsync_q;
    assign o_base_addr_weight = weight_q;
    assign o_base_addr_param  = param_q;
    assign o_layer_cfg        = layer_cfg_q;
    assign o_layer_start      = layer_start_q;
    assign o_busy             = (state_q == ST_BUSY);
    assign o_irq              = done_q;

endmodule

// File: tb/tb_cnn_accel_cfg_slave.sv
// Self-checking bench for cnn_accel_cfg_slave: directed vector table,
// hand-written corner sequences and randomized transactions against a
// transaction-level model of the register map and layer status.
module tb_cnn_accel_cfg_slave;

    localparam int K_W = 0;
    localparam int K_R = 1;
    localparam int K_D = 2;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        sl_HSEL = 1'b0;
    logic        sl_HREADY = 1'b1;
    logic [1:0]  sl_HTRANS = 2'b00;
    logic [2:0]  sl_HBURST = 3'b000;
    logic [2:0]  sl_HSIZE = 3'b010;
    logic [31:0] sl_HADDR = '0;
    logic        sl_HWRITE = 1'b0;
    logic [31:0] sl_HWDATA = '0;
    logic        out_sl_HREADY;
    logic [1:0]  out_sl_HRESP;
    logic [31:0] out_sl_HRDATA;
    logic        i_layer_done = 1'b0;
    logic [24:0] o_frame_size;
    logic [11:0] o_width, o_height;
    logic [11:0] o_start_up_delay, o_hsync_delay;
    logic [19:0] o_base_addr_weight;
    logic [11:0] o_base_addr_param;
    logic [15:0] o_layer_cfg;
    logic        o_layer_start, o_busy, o_irq;

    int n_total = 0;
    int n_bad = 0;
    int resp_bad = 0;

    cnn_accel_cfg_slave dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .sl_HSEL(sl_HSEL), .sl_HREADY(sl_HREADY),
        .sl_HTRANS(sl_HTRANS), .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE),
        .sl_HADDR(sl_HADDR), .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
        .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP),
        .out_sl_HRDATA(out_sl_HRDATA), .i_layer_done(i_layer_done),
        .o_frame_size(o_frame_size), .o_width(o_width), .o_height(o_height),
        .o_start_up_delay(o_start_up_delay), .o_hsync_delay(o_hsync_delay),
        .o_base_addr_weight(o_base_addr_weight), .o_base_addr_param(o_base_addr_param),
        .o_layer_cfg(o_layer_cfg), .o_layer_start(o_layer_start),
        .o_busy(o_busy), .o_irq(o_irq)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (out_sl_HRESP != 2'b00 || out_sl_HREADY != 1'b1) resp_bad++;
    end

    // ---------------- reference model (transaction level) ----------------
    logic [24:0] m_frame;
    logic [11:0] m_w, m_h, m_su, m_hs, m_param;
    logic [19:0] m_weight;
    logic [15:0] m_cfg;
    logic        m_running, m_done, m_err, m_pulse;

    function automatic void m_reset();
        m_frame = '0; m_w = '0; m_h = '0; m_su = '0; m_hs = '0;
        m_weight = '0; m_param = '0; m_cfg = '0;
        m_running = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pulse = 1'b0;
    endfunction

    function automatic void m_write(input logic [7:0] off, input logic [31:0] d);
        case (off)
            8'h00: if (!m_running) m_frame = d[24:0];
            8'h04: if (!m_running) begin m_w = d[11:0]; m_h = d[27:16]; end
            8'h08: if (!m_running) begin m_su = d[11:0]; m_hs = d[23:12]; end
            8'h0C: if (!m_running) begin m_weight = d[19:0]; m_param = d[31:20]; end
            8'h10: if (!m_running) m_cfg = d[15:0];
            8'h14: if (d[0]) begin
                if (m_running) m_err = 1'b1;
                else begin m_running = 1'b1; m_done = 1'b0; m_pulse = 1'b1; end
            end
            8'h18: begin
                if (d[2]) m_err = 1'b0;
                if (d[1]) m_done = 1'b0;
            end
            default: ;
        endcase
    endfunction

    function automatic void m_layer_done();
        if (m_running) begin m_running = 1'b0; m_done = 1'b1; end
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] off);
        case (off)
            8'h00: return {7'd0, m_frame};
            8'h04: return {4'd0, m_h, 4'd0, m_w};
            8'h08: return {8'd0, m_hs, m_su};
            8'h0C: return {m_param, m_weight};
            8'h10: return {16'd0, m_cfg};
            8'h18: return {29'd0, m_err, m_done, m_running};
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- bus helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [2:0] size,
                         input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        sl_HSEL = sel; sl_HTRANS = trans; sl_HSIZE = size;
        sl_HWRITE = wr; sl_HADDR = addr; sl_HWDATA = wdata;
        sl_HBURST = 3'($urandom_range(0, 7));
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_cycle(input logic [31:0] wdata);
        drive(1'b0, 2'b00, 3'b010, 1'b0, 32'h0, wdata);
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 2'($urandom_range(2, 3)), 3'b010, 1'b1, a, 32'h0);
        idle_cycle(d);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        drive(1'b1, 2'b10, 3'b010, 1'b0, a, 32'h0);
        d = out_sl_HRDATA;
    endtask

    task automatic pulse_done();
        i_layer_done = 1'b1;
        idle_cycle(32'h0);
        i_layer_done = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".frame"},  32'(o_frame_size), 32'(m_frame));
        check({tag, ".width"},  32'(o_width), 32'(m_w));
        check({tag, ".height"}, 32'(o_height), 32'(m_h));
        check({tag, ".su"},     32'(o_start_up_delay), 32'(m_su));
        check({tag, ".hs"},     32'(o_hsync_delay), 32'(m_hs));
        check({tag, ".weight"}, 32'(o_base_addr_weight), 32'(m_weight));
        check({tag, ".param"},  32'(o_base_addr_param), 32'(m_param));
        check({tag, ".cfg"},    32'(o_layer_cfg), 32'(m_cfg));
        check({tag, ".busy"},   32'(o_busy), 32'(m_running));
        check({tag, ".irq"},    32'(o_irq), 32'(m_done));
        check({tag, ".start"},  32'(o_layer_start), 32'(m_pulse));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_busy;
        logic        exp_irq;
        logic        exp_start;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int k, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] e, input logic b, input logic i, input logic s);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.exp_rd = e;
        v.exp_busy = b; v.exp_irq = i; v.exp_start = s;
        return v;
    endfunction

    logic [31:0] rd;
    logic [7:0]  offs [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};

    initial begin
        // reset state
        idle_cycle(32'h0);
        idle_cycle(32'h0);
        check("rst.hrdata", out_sl_HRDATA, 32'h0);
        check("rst.busy", 32'(o_busy), 32'h0);
        check("rst.irq", 32'(o_irq), 32'h0);
        check("rst.start", 32'(o_layer_start), 32'h0);
        check("rst.frame", 32'(o_frame_size), 32'h0);
        HRESETn = 1'b1;

        tbl.push_back(mk(K_W, 32'h00, 32'd16384,      32'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h04, 32'h0080_0080,  32'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h08, 32'h000A_00C8,  32'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h00, 32'h0, 32'd16384,      1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h04, 32'h0, 32'h0080_0080,  1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h08, 32'h0, 32'h000A_00C8,  1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h10, 32'hE905,       32'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h14, 32'h1,          32'h0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(K_R, 32'h18, 32'h0, 32'h1,          1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h00, 32'h5,          32'h0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h14, 32'h1,          32'h0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h18, 32'h0, 32'h5,          1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h00, 32'h0, 32'd16384,      1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(K_D, 32'h00, 32'h0, 32'h0,          1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(K_R, 32'h18, 32'h0, 32'h6,          1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(K_W, 32'h18, 32'h2,          32'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h18, 32'h0, 32'h4,          1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h18, 32'h4,          32'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h18, 32'h0, 32'h0,          1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h14, 32'h0, 32'h0,          1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h40, 32'h0, 32'h0,          1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h1C, 32'hFFFF_FFFF,  32'h0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h1C, 32'h0, 32'h0,          1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_R, 32'h10, 32'h0, 32'hE905,       1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_D, 32'h00, 32'h0, 32'h0,          1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(K_W, 32'h14, 32'h0,          32'h0, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            case (tbl[i].kind)
                K_W: ahb_write(tbl[i].addr, tbl[i].data);
                K_R: begin
                    ahb_read(tbl[i].addr, rd);
                    check($sformatf("vec%0d.rdata", i), rd, tbl[i].exp_rd);
                end
                default: pulse_done();
            endcase
            check($sformatf("vec%0d.busy", i), 32'(o_busy), 32'(tbl[i].exp_busy));
            check($sformatf("vec%0d.irq", i), 32'(o_irq), 32'(tbl[i].exp_irq));
            check($sformatf("vec%0d.start", i), 32'(o_layer_start), 32'(tbl[i].exp_start));
        end
        check("cfg.frame", 32'(o_frame_size), 32'd16384);
        check("cfg.width", 32'(o_width), 32'd128);
        check("cfg.height", 32'(o_height), 32'd128);
        check("cfg.su", 32'(o_start_up_delay), 32'd200);
        check("cfg.hs", 32'(o_hsync_delay), 32'd160);
        check("cfg.layer", 32'(o_layer_cfg), 32'hE905);

        // back-to-back write then read of the same offset (forwarding)
        drive(1'b1, 2'b10, 3'b010, 1'b1, 32'h0C, 32'h0);
        drive(1'b1, 2'b11, 3'b010, 1'b0, 32'h0C, 32'h1234_5678);
        check("b2b.rdata", out_sl_HRDATA, 32'h1234_5678);
        check("b2b.weight", 32'(o_base_addr_weight), 32'h45678);
        check("b2b.param", 32'(o_base_addr_param), 32'h123);
        ahb_read(32'h40, rd);
        check("unmapped.rdata", rd, 32'h0);

        // layer done and done-clear landing on the same edge in BUSY
        ahb_write(32'h14, 32'h1);
        check("sim.busy0", 32'(o_busy), 32'h1);
        drive(1'b1, 2'b10, 3'b010, 1'b1, 32'h18, 32'h0);
        i_layer_done = 1'b1;
        idle_cycle(32'h2);
        i_layer_done = 1'b0;
        check("sim.irq", 32'(o_irq), 32'h1);
        check("sim.busy1", 32'(o_busy), 32'h0);
        // restart straight from DONE
        ahb_write(32'h14, 32'h1);
        check("restart.busy", 32'(o_busy), 32'h1);
        check("restart.start", 32'(o_layer_start), 32'h1);
        check("restart.irq", 32'(o_irq), 32'h0);
        idle_cycle(32'h0);
        check("restart.pulse_len", 32'(o_layer_start), 32'h0);

        // reset during a write data phase while BUSY
        ahb_read(32'h18, rd);
        check("prerst.status", rd, 32'h1);
        drive(1'b1, 2'b10, 3'b010, 1'b1, 32'h10, 32'h0);
        HRESETn = 1'b0;
        idle_cycle(32'hABCD);
        check("midrst.busy", 32'(o_busy), 32'h0);
        check("midrst.irq", 32'(o_irq), 32'h0);
        check("midrst.start", 32'(o_layer_start), 32'h0);
        check("midrst.hrdata", out_sl_HRDATA, 32'h0);
        check("midrst.cfg", 32'(o_layer_cfg), 32'h0);
        check("midrst.frame", 32'(o_frame_size), 32'h0);
        check("midrst.weight", 32'(o_base_addr_weight), 32'h0);
        check("midrst.wh", {4'd0, o_height, 4'd0, o_width}, 32'h0);
        check("midrst.delay", {8'd0, o_hsync_delay, o_start_up_delay}, 32'h0);
        HRESETn = 1'b1;
        idle_cycle(32'hABCD);
        check("postrst.cfg", 32'(o_layer_cfg), 32'h0);
        ahb_write(32'h10, 32'h1234);
        check("postrst.first", 32'(o_layer_cfg), 32'h1234);

        // randomized transactions against the model
        HRESETn = 1'b0;
        idle_cycle(32'h0);
        HRESETn = 1'b1;
        m_reset();
        for (int n = 0; n < 300; n++) begin
            logic [7:0]  off;
            logic [31:0] d;
            int          op;
            op  = $urandom_range(0, 9);
            off = offs[$urandom_range(0, 8)];
            d   = $urandom;
            m_pulse = 1'b0;
            if (op <= 3) begin
                ahb_write(32'(off), d);
                m_write(off, d);
            end else if (op <= 6) begin
                logic [31:0] e;
                e = m_read(off);
                ahb_read(32'(off), rd);
                check($sformatf("rnd%0d.rdata@%02h", n, off), rd, e);
            end else if (op == 7) begin
                pulse_done();
                m_layer_done();
            end else if (op == 8) begin
                int       k;
                logic [2:0] sz;
                k  = $urandom_range(0, 4);
                sz = 3'($urandom_range(0, 6));
                if (sz >= 3'd2) sz = sz + 3'd1;
                if (k == 4) sl_HREADY = 1'b0;
                drive(k != 0, (k == 1) ? 2'b00 : (k == 2) ? 2'b01 : 2'b10,
                      (k == 3) ? sz : 3'b010, 1'b1, 32'(off), 32'h0);
                sl_HREADY = 1'b1;
                idle_cycle(d);
            end else begin
                logic [31:0] e;
                drive(1'b1, 2'b10, 3'b010, 1'b1, 32'(off), 32'h0);
                drive(1'b1, 2'b11, 3'b010, 1'b0, 32'(off), d);
                m_write(off, d);
                e = m_read(off);
                check($sformatf("rnd%0d.fwd@%02h", n, off), out_sl_HRDATA, e);
            end
            check_all($sformatf("rnd%0d", n));
        end

        idle_cycle(32'h0);
        check("resp_okay_cycles", 32'(resp_bad), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
